muldiv_wb_arbiter: RTL and testbench

- Receiving end of the mul/div result interface.
- Captures results from the final mul/div stage (valid, rd, result) into a small in-order FIFO and merges them onto the single register-file write port.
- The main pipeline writeback always has priority on that port.
- Exposes pending-rd hazard flags (and optional forwarding) to decode, plus backpressure to the mul/div issue logic.

---
 rtl/muldiv_wb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_wb_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_wb_arbiter.sv
// muldiv_wb_arbiter: collects mul/div results into a small in-order FIFO
// and merges them onto the single register-file write port. The main
// pipeline writeback always wins the port. Decode gets pending-rd hazard
// flags, and the mul/div issue logic gets a stall signal.
// Optional build macro MLWB_FWD_EN: when defined, the youngest live entry
// matching each decode source is forwarded. When undefined, the forwarding
// outputs are tied to zero.
//
// Handshake: ml_valid_i is a fire-and-forget strobe with no ready signal.
// The producer must honour ml_stall_o, which leaves one slot free for a
// result that is already in flight. A result that arrives while the FIFO
// is full is dropped, and this is recorded in the sticky overflow_o flag.
module muldiv_wb_arbiter #(
    parameter int WD_SIZE  = 32,
    parameter int REG_SIZE = 5,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ml_valid_i,
    input  logic [REG_SIZE-1:0] ml_rd_i,
    input  logic [WD_SIZE-1:0]  ml_result_i,
    input  logic                pipe_we_i,
    input  logic [REG_SIZE-1:0] pipe_rd_i,
    input  logic [WD_SIZE-1:0]  pipe_data_i,
    output logic                rf_we_o,
    output logic [REG_SIZE-1:0] rf_rd_o,
    output logic [WD_SIZE-1:0]  rf_data_o,
    output logic                ml_stall_o,
    input  logic [REG_SIZE-1:0] rs1_i,
    input  logic [REG_SIZE-1:0] rs2_i,
    output logic                haz1_o,
    output logic                haz2_o,
    output logic                fwd1_valid_o,
    output logic                fwd2_valid_o,
    output logic [WD_SIZE-1:0]  fwd1_data_o,
    output logic [WD_SIZE-1:0]  fwd2_data_o,
    output logic                overflow_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // FIFO storage. Only the live bits need a reset: a slot's rd and data
    // are always written before that slot can be popped.
    logic [REG_SIZE-1:0] rd_q   [DEPTH];
    logic [WD_SIZE-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]    live_q, live_d;
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;

    logic                rf_we_q, rf_we_d;
    logic [REG_SIZE-1:0] rf_rd_q, rf_rd_d;
    logic [WD_SIZE-1:0]  rf_data_q, rf_data_d;
    logic                overflow_q, overflow_d;

    logic waw_drop, push_cand, fifo_full, fifo_empty;
    logic do_pop, do_bypass, do_push;

    // Classify this cycle's mul/div result and decide which source drives the write port.
    always_comb begin
        waw_drop   = pipe_we_i && ml_valid_i && (ml_rd_i == pipe_rd_i);
        push_cand  = ml_valid_i && (ml_rd_i != '0) && !waw_drop;
        fifo_full  = (count_q == CW'(DEPTH));
        fifo_empty = (count_q == '0);
        do_pop     = !pipe_we_i && !fifo_empty;
        // A bypass is allowed only when nothing is queued, so arrival order is kept.
        do_bypass  = !pipe_we_i && fifo_empty && push_cand;
        do_push    = push_cand && !fifo_full && !do_bypass;
    end

    // Next state for the FIFO pointers, live bits, write port and overflow flag.
    always_comb begin
        live_d     = live_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_data_d  = rf_data_q;
        overflow_d = overflow_q | (push_cand && fifo_full);

        // A pipeline write makes older pending results to the same rd obsolete.
        if (pipe_we_i && (pipe_rd_i != '0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == pipe_rd_i) live_d[i] = 1'b0;
            end
        end

        if (pipe_we_i) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = pipe_rd_i;
            rf_data_d = pipe_data_i;
        end else if (do_pop) begin
            rf_we_d   = live_q[head_q];
            rf_rd_d   = rd_q[head_q];
            rf_data_d = data_q[head_q];
        end else if (do_bypass) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = ml_rd_i;
            rf_data_d = ml_result_i;
        end

        if (do_pop) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + PW'(1);
        end
        if (do_push) begin
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Control state register with a synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            live_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            live_q     <= live_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_data_q  <= rf_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage: write the tail slot when a result is enqueued.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            rd_q[tail_q]   <= ml_rd_i;
            data_q[tail_q] <= ml_result_i;
        end
    end

    // Hazard flags come from registered FIFO state only.
    always_comb begin
        haz1_o = 1'b0;
        haz2_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (rd_q[i] == rs1_i)) haz1_o = 1'b1;
            if (live_q[i] && (rd_q[i] == rs2_i)) haz2_o = 1'b1;
        end
        if (rs1_i == '0) haz1_o = 1'b0;
        if (rs2_i == '0) haz2_o = 1'b0;
    end

`ifdef MLWB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Walk from oldest to youngest, so the last match found is the youngest.
    always_comb begin
        fwd_idx     = '0;
        fwd1_data_o = '0;
        fwd2_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if (live_q[fwd_idx] && (rd_q[fwd_idx] == rs1_i)) fwd1_data_o = data_q[fwd_idx];
            if (live_q[fwd_idx] && (rd_q[fwd_idx] == rs2_i)) fwd2_data_o = data_q[fwd_idx];
        end
        fwd1_valid_o = haz1_o;
        fwd2_valid_o = haz2_o;
    end
`else
    assign fwd1_valid_o = 1'b0;
    assign fwd2_valid_o = 1'b0;
    assign fwd1_data_o  = '0;
    assign fwd2_data_o  = '0;
`endif

    assign ml_stall_o = (count_q >= CW'(DEPTH - 1));
    assign rf_we_o    = rf_we_q;
    assign rf_rd_o    = rf_rd_q;
    assign rf_data_o  = rf_data_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
// Testbench for muldiv_wb_arbiter. The reference model keeps the pending
// results in a queue. Each cycle it produces the expected register-file
// write and the expected overflow state. A monitor process compares these
// one edge later.
module tb_muldiv_wb_arbiter;

    localparam int WD    = 32;
    localparam int RS    = 5;
    localparam int DEPTH = 4;
    localparam int EW    = 1 + 1 + RS + WD;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          ml_valid_i;
    logic [RS-1:0] ml_rd_i;
    logic [WD-1:0] ml_result_i;
    logic          pipe_we_i;
    logic [RS-1:0] pipe_rd_i;
    logic [WD-1:0] pipe_data_i;
    logic          rf_we_o;
    logic [RS-1:0] rf_rd_o;
    logic [WD-1:0] rf_data_o;
    logic          ml_stall_o;
    logic [RS-1:0] rs1_i, rs2_i;
    logic          haz1_o, haz2_o;
    logic          fwd1_valid_o, fwd2_valid_o;
    logic [WD-1:0] fwd1_data_o, fwd2_data_o;
    logic          overflow_o;

    muldiv_wb_arbiter #(.WD_SIZE(WD), .REG_SIZE(RS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .ml_valid_i(ml_valid_i), .ml_rd_i(ml_rd_i), .ml_result_i(ml_result_i),
        .pipe_we_i(pipe_we_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
        .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o),
        .ml_stall_o(ml_stall_o), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .haz1_o(haz1_o), .haz2_o(haz2_o),
        .fwd1_valid_o(fwd1_valid_o), .fwd2_valid_o(fwd2_valid_o),
        .fwd1_data_o(fwd1_data_o), .fwd2_data_o(fwd2_data_o),
        .overflow_o(overflow_o)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          live;
        logic [RS-1:0] rd;
        logic [WD-1:0] data;
    } ent_t;

    ent_t          mq[$];
    logic          m_ov;
    logic [RS-1:0] m_last_rd;
    logic [WD-1:0] m_last_data;

    // Expected entry layout: {overflow, we, rd, data}.
    logic [EW-1:0] exp_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_haz(input logic [RS-1:0] rs);
        logic h;
        h = 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].rd == rs) h = 1'b1;
        return h && (rs != '0);
    endfunction

    function automatic logic [WD-1:0] model_fwd(input logic [RS-1:0] rs);
        logic [WD-1:0] d;
        d = '0;
        foreach (mq[i]) if (mq[i].live && mq[i].rd == rs) d = mq[i].data;
        return d;
    endfunction

    // ---------------- driver ----------------
    // Apply one cycle of inputs, check the combinational outputs against the
    // current model state, then advance the model and queue the expected write.
    task automatic step(input logic rst, input logic pv, input logic [RS-1:0] prd,
                        input logic [WD-1:0] pd, input logic mv, input logic [RS-1:0] mrd,
                        input logic [WD-1:0] md, input logic [RS-1:0] r1,
                        input logic [RS-1:0] r2);
        logic          waw, cand, full, bypass, owe;
        logic [RS-1:0] ord;
        logic [WD-1:0] odt;
        ent_t          e;
        @(negedge clk);
        reset = rst; pipe_we_i = pv; pipe_rd_i = prd; pipe_data_i = pd;
        ml_valid_i = mv; ml_rd_i = mrd; ml_result_i = md; rs1_i = r1; rs2_i = r2;
        #1;
        chk("stall", ml_stall_o, mq.size() >= DEPTH - 1);
        chk("haz1", haz1_o, model_haz(r1));
        chk("haz2", haz2_o, model_haz(r2));
`ifdef MLWB_FWD_EN
        chk("fwd1_valid", fwd1_valid_o, model_haz(r1));
        chk("fwd2_valid", fwd2_valid_o, model_haz(r2));
        if (model_haz(r1)) chk("fwd1_data", fwd1_data_o, model_fwd(r1));
        if (model_haz(r2)) chk("fwd2_data", fwd2_data_o, model_fwd(r2));
`else
        chk("fwd1_valid", fwd1_valid_o, 0);
        chk("fwd1_data", fwd1_data_o, 0);
        chk("fwd2_valid", fwd2_valid_o, 0);
`endif
        if (rst) begin
            mq.delete();
            m_ov = 1'b0; m_last_rd = '0; m_last_data = '0;
            owe = 1'b0; ord = '0; odt = '0;
        end else begin
            waw    = pv && mv && (mrd == prd);
            cand   = mv && (mrd != '0) && !waw;
            full   = (mq.size() == DEPTH);
            bypass = 1'b0;
            if (pv && prd != '0) foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 1'b0;
            if (pv) begin
                owe = 1'b1; ord = prd; odt = pd;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                owe = e.live; ord = e.rd; odt = e.data;
            end else if (cand) begin
                owe = 1'b1; ord = mrd; odt = md; bypass = 1'b1;
            end else begin
                owe = 1'b0; ord = m_last_rd; odt = m_last_data;
            end
            m_last_rd = ord; m_last_data = odt;
            if (cand && !bypass) begin
                if (!full) begin
                    e.live = 1'b1; e.rd = mrd; e.data = md;
                    mq.push_back(e);
                end else begin
                    m_ov = 1'b1;
                end
            end
        end
        exp_q.push_back({m_ov, owe, ord, odt});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [EW-1:0] exp_v;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk("rf_we", rf_we_o, exp_v[WD+RS]);
            chk("rf_rd", rf_rd_o, exp_v[WD+RS-1:WD]);
            chk("rf_data", rf_data_o, exp_v[WD-1:0]);
            chk("overflow", overflow_o, exp_v[WD+RS+1]);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; pipe_we_i = 0; pipe_rd_i = 0; pipe_data_i = 0;
        ml_valid_i = 0; ml_rd_i = 0; ml_result_i = 0; rs1_i = 0; rs2_i = 0;
        m_ov = 0; m_last_rd = 0; m_last_data = 0;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Bypass into an empty FIFO.
        step(0, 0, 0, 0, 1, 5, 32'h2A, 5, 0);
        idle(1);

        // The pipe holds the port while three results queue up, and the stall flag rises.
        step(0, 1, 3, 32'h33, 1, 7, 32'h70, 7, 8);
        step(0, 1, 3, 32'h34, 1, 8, 32'h80, 7, 8);
        step(0, 1, 3, 32'h35, 1, 9, 32'h90, 9, 8);
        step(0, 1, 3, 32'h36, 0, 0, 0, 9, 7);
        idle(4);

        // A pipe write squashes the queued rd 6 entry.
        step(0, 1, 1, 32'h01, 1, 6, 32'h11, 6, 0);
        step(0, 1, 6, 32'h66, 0, 0, 0, 6, 0);
        step(0, 0, 0, 0, 0, 0, 0, 6, 0);
        idle(2);

        // Same-cycle WAW, then a result to rd 0.
        step(0, 1, 4, 32'h44, 1, 4, 32'hDEAD, 4, 0);
        step(0, 0, 0, 0, 1, 0, 32'hBEEF, 0, 0);
        idle(2);

        // Fill the FIFO, overflow it, then reset while entries are still queued.
        for (int i = 0; i < 5; i++) step(0, 1, 1, i, 1, RS'(10 + i), 32'h100 + i, 10, 13);
        step(0, 1, 1, 32'h5, 0, 0, 0, 11, 12);
        step(0, 0, 0, 0, 0, 0, 0, 12, 13);
        step(1, 0, 0, 0, 0, 0, 0, 12, 13);
        step(0, 0, 0, 0, 0, 0, 0, 12, 13);

        // Two results to the same rd: the younger one must be forwarded.
        step(0, 1, 1, 0, 1, 2, 32'hA, 2, 0);
        step(0, 1, 1, 0, 1, 2, 32'hB, 2, 0);
        step(0, 1, 1, 0, 0, 0, 0, 2, 2);
        idle(3);

        // Randomized traffic that alternates between light and heavy pipe use.
        for (int i = 0; i < 1500; i++) begin
            int bias;
            bias = ((i / 250) % 2 == 1) ? 75 : 25;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < bias, RS'($urandom_range(0, 9)), $urandom,
                 $urandom_range(0, 99) < 60, RS'($urandom_range(0, 9)), $urandom,
                 RS'($urandom_range(0, 9)), RS'($urandom_range(0, 9)));
        end
        idle(6);

        repeat (2) @(posedge clk);
        #2;
        chk("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
